// File: rtl/video_layer_compositor_if.sv
// Pixel, configuration and status bundle for the layer compositor.
// The master side drives pixels and config; the slave side is the compositor.
interface video_layer_compositor_if #(
    parameter int NUM_LAYERS = 4
);
    logic                    valid_in;
    logic                    frame_start_in;
    logic [1:0]              bg_sel_in;
    logic [23:0]             camera_pixel_in;
    logic [7:0]              camera_y_in;
    logic [7:0]              channel_in;
    logic                    thresholded_pixel_in;
    logic [24*NUM_LAYERS-1:0] layer_pixel_in;
    logic [NUM_LAYERS-1:0]   layer_hit_in;
    logic [NUM_LAYERS-1:0]   layer_en_in;
    logic [2*NUM_LAYERS-1:0] layer_alpha_in;
    logic                    test_mode_in;
    logic [23:0]             pixel_out;
    logic                    valid_out;
    logic                    fade_busy_out;
    logic [1:0]              active_bg_out;

    modport master (
        output valid_in, frame_start_in, bg_sel_in, camera_pixel_in, camera_y_in,
               channel_in, thresholded_pixel_in, layer_pixel_in, layer_hit_in,
               layer_en_in, layer_alpha_in, test_mode_in,
        input  pixel_out, valid_out, fade_busy_out, active_bg_out
    );

    modport slave (
        input  valid_in, frame_start_in, bg_sel_in, camera_pixel_in, camera_y_in,
               channel_in, thresholded_pixel_in, layer_pixel_in, layer_hit_in,
               layer_en_in, layer_alpha_in, test_mode_in,
        output pixel_out, valid_out, fade_busy_out, active_bg_out
    );
endinterface

// File: rtl/video_layer_compositor.sv
// Three-stage background select / crossfade / overlay compositor with
// frame-synchronous configuration capture.
module video_layer_compositor #(
    parameter int          NUM_LAYERS = 4,
    parameter int          FADE_LOG2  = 3,
    parameter logic [23:0] MASK_COLOR = 24'hFF77AA,
    parameter logic [23:0] TEST_COLOR = 24'hFF7700
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    video_layer_compositor_if.slave  vif
);
    localparam int KW = FADE_LOG2 + 1;
    localparam int BW = 8 + FADE_LOG2 + 1;
    localparam logic [KW-1:0] K_FULL = KW'(1 << FADE_LOG2);

    function automatic logic [23:0] bg_color(input logic [1:0] sel, input logic [23:0] cam,
                                             input logic [7:0] y, input logic [7:0] ch,
                                             input logic thr);
        logic [23:0] color;
        case (sel)
            2'b00:   color = cam;
            2'b01:   color = {ch, ch, ch};
            2'b10:   color = thr ? 24'hFFFFFF : 24'h000000;
            default: color = thr ? MASK_COLOR : {y, y, y};
        endcase
        return color;
    endfunction

    function automatic logic [23:0] apply_layer(input logic [23:0] c, input logic [23:0] l,
                                                input logic [1:0] a);
        logic [23:0] result;
        logic [9:0]  cc, ll, sum;
        result = '0;
        for (int ch = 0; ch < 3; ch++) begin
            cc = {2'b00, c[8*ch +: 8]};
            ll = {2'b00, l[8*ch +: 8]};
            // every alpha code is expressed as a quarter-weighted sum so one >>2 finishes it
            case (a)
                2'b00:   sum = ll << 2;
                2'b01:   sum = (ll << 1) + ll + cc;
                2'b10:   sum = (ll + cc) << 1;
                default: sum = ll + (cc << 1) + cc;
            endcase
            result[8*ch +: 8] = 8'(sum >> 2);
        end
        return result;
    endfunction

    // Frame-synchronous configuration and fade state
    logic [1:0]              old_bg_reg, old_bg_next;
    logic [1:0]              active_bg_reg, active_bg_next;
    logic [KW-1:0]           k_reg, k_next;
    logic [NUM_LAYERS-1:0]   en_reg, en_next;
    logic [2*NUM_LAYERS-1:0] alpha_reg, alpha_next;
    logic                    test_reg, test_next;
    logic                    capture;

    assign capture = vif.valid_in && vif.frame_start_in;

    // The _next values are also what the current pixel uses, so a capture applies to its own pixel.
    always_comb begin
        old_bg_next    = old_bg_reg;
        active_bg_next = active_bg_reg;
        k_next         = k_reg;
        en_next        = en_reg;
        alpha_next     = alpha_reg;
        test_next      = test_reg;
        if (capture) begin
            en_next    = vif.layer_en_in;
            alpha_next = vif.layer_alpha_in;
            test_next  = vif.test_mode_in;
            if (vif.bg_sel_in != active_bg_reg) begin
                old_bg_next    = active_bg_reg;
                active_bg_next = vif.bg_sel_in;
                k_next         = '0;
            end else if (k_reg < K_FULL) begin
                k_next = k_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            old_bg_reg    <= '0;
            active_bg_reg <= '0;
            k_reg         <= K_FULL;
            en_reg        <= '0;
            alpha_reg     <= '0;
            test_reg      <= 1'b0;
        end else begin
            old_bg_reg    <= old_bg_next;
            active_bg_reg <= active_bg_next;
            k_reg         <= k_next;
            en_reg        <= en_next;
            alpha_reg     <= alpha_next;
            test_reg      <= test_next;
        end
    end

    // Stage 1: both candidate backgrounds plus everything later stages need
    logic [23:0]             s1_old_reg, s1_new_reg;
    logic [KW-1:0]           s1_k_reg;
    logic [NUM_LAYERS-1:0]   s1_en_reg, s1_hit_reg;
    logic [2*NUM_LAYERS-1:0] s1_alpha_reg;
    logic [24*NUM_LAYERS-1:0] s1_layer_reg;
    logic                    s1_test_reg, s1_valid_reg;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_old_reg   <= '0;
            s1_new_reg   <= '0;
            s1_k_reg     <= '0;
            s1_en_reg    <= '0;
            s1_hit_reg   <= '0;
            s1_alpha_reg <= '0;
            s1_layer_reg <= '0;
            s1_test_reg  <= 1'b0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_old_reg   <= bg_color(old_bg_next, vif.camera_pixel_in, vif.camera_y_in,
                                     vif.channel_in, vif.thresholded_pixel_in);
            s1_new_reg   <= bg_color(active_bg_next, vif.camera_pixel_in, vif.camera_y_in,
                                     vif.channel_in, vif.thresholded_pixel_in);
            s1_k_reg     <= k_next;
            s1_en_reg    <= en_next;
            s1_hit_reg   <= vif.layer_hit_in;
            s1_alpha_reg <= alpha_next;
            s1_layer_reg <= vif.layer_pixel_in;
            s1_test_reg  <= test_next;
            s1_valid_reg <= vif.valid_in;
        end
    end

    // Stage 2: crossfade; at k = S the old weight is zero so the result is exactly new
    logic [BW-1:0] mix [3];
    logic [23:0]   blend;

    for (genvar gi = 0; gi < 3; gi++) begin : g_blend
        assign mix[gi] = BW'(s1_old_reg[8*gi +: 8]) * BW'(K_FULL - s1_k_reg)
                       + BW'(s1_new_reg[8*gi +: 8]) * BW'(s1_k_reg);
        assign blend[8*gi +: 8] = 8'(mix[gi] >> FADE_LOG2);
    end

    logic [23:0]             s2_blend_reg;
    logic [NUM_LAYERS-1:0]   s2_en_reg, s2_hit_reg;
    logic [2*NUM_LAYERS-1:0] s2_alpha_reg;
    logic [24*NUM_LAYERS-1:0] s2_layer_reg;
    logic                    s2_test_reg, s2_valid_reg;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_blend_reg <= '0;
            s2_en_reg    <= '0;
            s2_hit_reg   <= '0;
            s2_alpha_reg <= '0;
            s2_layer_reg <= '0;
            s2_test_reg  <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            s2_blend_reg <= blend;
            s2_en_reg    <= s1_en_reg;
            s2_hit_reg   <= s1_hit_reg;
            s2_alpha_reg <= s1_alpha_reg;
            s2_layer_reg <= s1_layer_reg;
            s2_test_reg  <= s1_test_reg;
            s2_valid_reg <= s1_valid_reg;
        end
    end

    // Stage 3: layers applied bottom-up, so the highest index lands on top
    logic [23:0] chain [NUM_LAYERS+1];
    assign chain[0] = s2_blend_reg;

    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
        assign chain[gi+1] = (s2_en_reg[gi] && s2_hit_reg[gi])
                           ? apply_layer(chain[gi], s2_layer_reg[24*gi +: 24], s2_alpha_reg[2*gi +: 2])
                           : chain[gi];
    end

    logic [23:0] pixel_reg;
    logic        valid_out_reg;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pixel_reg     <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            pixel_reg     <= s2_test_reg ? TEST_COLOR : chain[NUM_LAYERS];
            valid_out_reg <= s2_valid_reg;
        end
    end

    assign vif.pixel_out     = pixel_reg;
    assign vif.valid_out     = valid_out_reg;
    assign vif.fade_busy_out = (k_reg < K_FULL);
    assign vif.active_bg_out = active_bg_reg;

endmodule

// File: tb/tb_video_layer_compositor.sv
// Directed bench for video_layer_compositor: reset, capture gating, crossfade,
// fade restart, layer alpha/priority, test mode and asynchronous reset.
module tb_video_layer_compositor;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    video_layer_compositor_if #(.NUM_LAYERS(4)) vif ();

    video_layer_compositor #(
        .NUM_LAYERS(4),
        .FADE_LOG2 (3),
        .MASK_COLOR(24'hFF77AA),
        .TEST_COLOR(24'hFF7700)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .vif     (vif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_idle();
        vif.valid_in             = 1'b0;
        vif.frame_start_in       = 1'b0;
        vif.bg_sel_in            = 2'b00;
        vif.camera_pixel_in      = 24'h0;
        vif.camera_y_in          = 8'h0;
        vif.channel_in           = 8'h0;
        vif.thresholded_pixel_in = 1'b0;
        vif.layer_pixel_in       = '0;
        vif.layer_hit_in         = '0;
        vif.layer_en_in          = '0;
        vif.layer_alpha_in       = '0;
        vif.test_mode_in         = 1'b0;
    endtask

    // One valid pixel clocked in; afterwards the bus is idle again.
    task automatic push(input logic fs);
        vif.valid_in       = 1'b1;
        vif.frame_start_in = fs;
        tick(1);
        vif.valid_in       = 1'b0;
        vif.frame_start_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vif.valid_in        = i[0];
            vif.frame_start_in  = 1'b1;
            vif.bg_sel_in       = 2'(i);
            vif.camera_pixel_in = 24'($urandom);
            vif.layer_en_in     = 4'hF;
            vif.layer_hit_in    = 4'hF;
            vif.test_mode_in    = i[1];
            tick(1);
            checks++;
            if (vif.pixel_out !== 24'h0 || vif.valid_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: pixel=%h valid=%b, expected 000000/0",
                         i, vif.pixel_out, vif.valid_out);
            end
        end
        checks++;
        if (vif.fade_busy_out !== 1'b0 || vif.active_bg_out !== 2'b00) begin
            errors++;
            $display("FAIL reset_status: busy=%b active=%0d, expected 0/0",
                     vif.fade_busy_out, vif.active_bg_out);
        end
        set_idle();
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_passthrough();
        vif.camera_pixel_in = 24'h123456;
        vif.bg_sel_in       = 2'b00;
        push(1'b1);
        checks++;
        if (vif.valid_out !== 1'b0) begin
            errors++; $display("FAIL latency_1: valid_out=%b expected 0", vif.valid_out);
        end
        tick(1);
        checks++;
        if (vif.valid_out !== 1'b0) begin
            errors++; $display("FAIL latency_2: valid_out=%b expected 0", vif.valid_out);
        end
        tick(1);
        checks++;
        if (vif.valid_out !== 1'b1 || vif.pixel_out !== 24'h123456) begin
            errors++;
            $display("FAIL latency_3: valid=%b pixel=%h expected 1/123456", vif.valid_out, vif.pixel_out);
        end
        tick(1);
        checks++;
        if (vif.valid_out !== 1'b0) begin
            errors++; $display("FAIL latency_4: valid_out=%b expected 0", vif.valid_out);
        end
    endtask

    task automatic test_fade();
        logic [23:0] exp_px;
        vif.camera_pixel_in = 24'hFF0000;
        vif.channel_in      = 8'h80;
        vif.bg_sel_in       = 2'b01;
        push(1'b0);
        tick(2);
        checks++;
        if (vif.pixel_out !== 24'hFF0000 || vif.active_bg_out !== 2'b00) begin
            errors++;
            $display("FAIL midframe_sel: pixel=%h active=%0d expected FF0000/0", vif.pixel_out, vif.active_bg_out);
        end
        for (int f = 0; f < 9; f++) begin
            push(1'b1);
            checks++;
            if (vif.fade_busy_out !== (f < 8)) begin
                errors++;
                $display("FAIL fade_busy frame %0d: got %b expected %b", f, vif.fade_busy_out, (f < 8));
            end
            tick(2);
            // k = f here; (255*(8-k) + 128*k) >> 3 for red, (128*k) >> 3 for green/blue
            exp_px = (f == 0) ? 24'hFF0000 : (f == 4) ? 24'hBF4040 : 24'h808080;
            if (f == 0 || f == 4 || f == 8) begin
                checks++;
                if (vif.pixel_out !== exp_px) begin
                    errors++;
                    $display("FAIL fade_pixel frame %0d: got %h expected %h", f, vif.pixel_out, exp_px);
                end
            end
        end
        checks++;
        if (vif.active_bg_out !== 2'b01) begin
            errors++; $display("FAIL fade_active: got %0d expected 1", vif.active_bg_out);
        end
    endtask

    task automatic test_restart();
        do_reset();
        vif.camera_pixel_in      = 24'hFF0000;
        vif.channel_in           = 8'h80;
        vif.thresholded_pixel_in = 1'b1;
        vif.bg_sel_in            = 2'b01;
        for (int i = 0; i < 4; i++) push(1'b1);
        vif.bg_sel_in = 2'b10;
        push(1'b1);
        checks++;
        if (vif.active_bg_out !== 2'b10 || vif.fade_busy_out !== 1'b1) begin
            errors++;
            $display("FAIL restart_status: active=%0d busy=%b expected 2/1", vif.active_bg_out, vif.fade_busy_out);
        end
        tick(2);
        // old background is now channel gray, shown fully at k=0
        checks++;
        if (vif.pixel_out !== 24'h808080) begin
            errors++; $display("FAIL restart_k0: got %h expected 808080", vif.pixel_out);
        end
        push(1'b1);
        tick(2);
        // k=1: (0x80*7 + 0xFF) >> 3 = 0x8F
        checks++;
        if (vif.pixel_out !== 24'h8F8F8F || vif.fade_busy_out !== 1'b1) begin
            errors++;
            $display("FAIL restart_k1: pixel=%h busy=%b expected 8F8F8F/1", vif.pixel_out, vif.fade_busy_out);
        end
        do_reset();
        vif.bg_sel_in = 2'b00;
        push(1'b1);
        checks++;
        if (vif.fade_busy_out !== 1'b0 || vif.active_bg_out !== 2'b00) begin
            errors++;
            $display("FAIL same_sel: busy=%b active=%0d expected 0/0", vif.fade_busy_out, vif.active_bg_out);
        end
        tick(2);
        checks++;
        if (vif.pixel_out !== 24'hFF0000) begin
            errors++; $display("FAIL same_sel_pixel: got %h expected FF0000", vif.pixel_out);
        end
    endtask

    task automatic test_layers();
        do_reset();
        vif.thresholded_pixel_in = 1'b0;
        vif.camera_pixel_in = 24'h000000;
        vif.bg_sel_in       = 2'b00;
        vif.layer_pixel_in  = {24'h00FF00, 24'h445566, 24'h112233, 24'h0000FF};
        vif.layer_hit_in    = 4'b1111;
        vif.layer_en_in     = 4'b1001;
        vif.layer_alpha_in  = 8'b00_00_00_00;
        push(1'b1);
        tick(2);
        checks++;
        if (vif.pixel_out !== 24'h00FF00) begin
            errors++; $display("FAIL layer_priority: got %h expected 00FF00", vif.pixel_out);
        end
        vif.layer_pixel_in = {24'hFF00FF, 24'h445566, 24'h112233, 24'h0000FF};
        vif.layer_en_in    = 4'b1000;
        vif.layer_alpha_in = 8'b10_00_00_00;
        push(1'b1);
        tick(2);
        checks++;
        if (vif.pixel_out !== 24'h7F007F) begin
            errors++; $display("FAIL layer_alpha10: got %h expected 7F007F", vif.pixel_out);
        end
        vif.layer_alpha_in = 8'b01_00_00_00;
        push(1'b1);
        tick(2);
        checks++;
        if (vif.pixel_out !== 24'hBF00BF) begin
            errors++; $display("FAIL layer_alpha01: got %h expected BF00BF", vif.pixel_out);
        end
        vif.layer_alpha_in = 8'b11_00_00_00;
        push(1'b1);
        tick(2);
        checks++;
        if (vif.pixel_out !== 24'h3F003F) begin
            errors++; $display("FAIL layer_alpha11: got %h expected 3F003F", vif.pixel_out);
        end
        vif.layer_en_in    = 4'b0000;
        vif.layer_alpha_in = 8'b00_00_00_00;
        vif.test_mode_in   = 1'b1;
        push(1'b0);
        tick(2);
        checks++;
        if (vif.pixel_out !== 24'h3F003F) begin
            errors++; $display("FAIL midframe_cfg: got %h expected 3F003F", vif.pixel_out);
        end
        vif.test_mode_in   = 1'b0;
        vif.layer_en_in    = 4'b1001;
        vif.layer_alpha_in = 8'b10_00_00_00;
        push(1'b1);
        tick(2);
        checks++;
        if (vif.pixel_out !== 24'h7F00FF) begin
            errors++; $display("FAIL layer_order: got %h expected 7F00FF", vif.pixel_out);
        end
    endtask

    task automatic test_test_mode();
        vif.test_mode_in   = 1'b1;
        vif.layer_en_in    = 4'b1111;
        vif.layer_alpha_in = 8'b00_00_00_00;
        push(1'b1);
        tick(2);
        checks++;
        if (vif.pixel_out !== 24'hFF7700) begin
            errors++; $display("FAIL test_mode: got %h expected FF7700", vif.pixel_out);
        end
        vif.test_mode_in   = 1'b0;
        vif.bg_sel_in      = 2'b01;
        vif.valid_in       = 1'b0;
        vif.frame_start_in = 1'b1;
        tick(1);
        vif.frame_start_in = 1'b0;
        checks++;
        if (vif.active_bg_out !== 2'b00 || vif.fade_busy_out !== 1'b0) begin
            errors++;
            $display("FAIL invalid_fs_status: active=%0d busy=%b expected 0/0", vif.active_bg_out, vif.fade_busy_out);
        end
        push(1'b0);
        tick(2);
        checks++;
        if (vif.pixel_out !== 24'hFF7700) begin
            errors++; $display("FAIL invalid_fs_pixel: got %h expected FF7700", vif.pixel_out);
        end
    endtask

    task automatic test_async_reset();
        set_idle();
        do_reset();
        vif.camera_pixel_in = 24'h123456;
        vif.channel_in      = 8'h80;
        vif.bg_sel_in       = 2'b01;
        push(1'b1);
        vif.valid_in = 1'b1;
        tick(2);
        checks++;
        if (vif.valid_out !== 1'b1 || vif.pixel_out !== 24'h123456 || vif.fade_busy_out !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: valid=%b pixel=%h busy=%b expected 1/123456/1",
                     vif.valid_out, vif.pixel_out, vif.fade_busy_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vif.pixel_out !== 24'h0 || vif.valid_out !== 1'b0 ||
            vif.fade_busy_out !== 1'b0 || vif.active_bg_out !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: pixel=%h valid=%b busy=%b active=%0d expected 0/0/0/0",
                     vif.pixel_out, vif.valid_out, vif.fade_busy_out, vif.active_bg_out);
        end
        vif.valid_in = 1'b0;
        tick(1);
        rst_n = 1'b1;
        vif.bg_sel_in = 2'b00;
        push(1'b1);
        checks++;
        if (vif.fade_busy_out !== 1'b0 || vif.active_bg_out !== 2'b00) begin
            errors++;
            $display("FAIL post_reset: busy=%b active=%0d expected 0/0", vif.fade_busy_out, vif.active_bg_out);
        end
        tick(2);
        checks++;
        if (vif.pixel_out !== 24'h123456) begin
            errors++; $display("FAIL post_reset_pixel: got %h expected 123456", vif.pixel_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_idle();
        tick(1);
        test_reset();
        test_passthrough();
        test_fade();
        test_restart();
        test_layers();
        test_test_mode();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
